// File: rtl/dmem_pkg.sv
// Shared types for the data-memory bridge: FSM states, store-buffer entry and defaults.
package dmem_pkg;

    localparam int unsigned N_DEF        = 64;
    localparam int unsigned SB_DEPTH_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        RD_REQ,
        RD_WAIT,
        RD_DONE
    } state_t;

    typedef struct packed {
        logic [N_DEF-1:0] addr;
        logic [N_DEF-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_fifo.sv
// In-order store buffer: power-of-two depth FIFO with occupancy count and head output.
module store_fifo #(
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned W     = 128,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count,
    output logic [W-1:0]  o_head
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + PW'(1);
            if (w_pop)  r_rd <= r_rd + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/dmem_bridge.sv
// Single-cycle data-memory port to multi-cycle req/ready + rvalid RAM bridge,
// with posted stores in an in-order buffer and stalling loads.
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int unsigned N        = N_DEF,
    parameter int unsigned SB_DEPTH = SB_DEPTH_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] DM_addr,
    input  logic [N-1:0] DM_writeData,
    input  logic         DM_writeEnable,
    input  logic         DM_readEnable,
    output logic [N-1:0] DM_readData,
    output logic         stall,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic         mem_ready,
    input  logic         mem_rvalid,
    input  logic [N-1:0] mem_rdata
);

    localparam int unsigned CW = $clog2(SB_DEPTH + 1);

    state_t          r_state;
    state_t          w_next;
    logic [N-1:0]    r_rdata;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    logic [2*N-1:0]  w_head;
    logic            w_drain_st;
    logic            w_push;
    logic            w_pop;

    assign w_drain_st = (r_state == IDLE) || (r_state == DRAIN);
    assign w_pop      = w_drain_st & ~w_empty & mem_ready;
    // A simultaneous load and store is treated as a load only.
    assign w_push     = DM_writeEnable & ~DM_readEnable & ~stall;

    store_fifo #(
        .DEPTH (SB_DEPTH),
        .W     (2 * N)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  ({DM_addr, DM_writeData}),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_head  (w_head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == RD_WAIT && mem_rvalid) r_rdata <= mem_rdata;
        end
    end

    always_comb begin
        w_next    = r_state;
        stall     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_drain_st && !w_empty) begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = w_head[2*N-1:N];
            mem_wdata = w_head[N-1:0];
        end
        case (r_state)
            IDLE: begin
                if (DM_readEnable) begin
                    stall  = 1'b1;
                    w_next = w_empty ? RD_REQ : DRAIN;
                end else begin
                    stall = DM_writeEnable & w_full;
                end
            end
            DRAIN: begin
                stall = 1'b1;
                // The last entry may already have left while still in IDLE.
                if (w_empty || (w_count == CW'(1) && w_pop)) w_next = RD_REQ;
            end
            RD_REQ: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = DM_addr;
                if (mem_ready) w_next = RD_WAIT;
            end
            RD_WAIT: begin
                stall = 1'b1;
                if (mem_rvalid) w_next = RD_DONE;
            end
            RD_DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign DM_readData = r_rdata;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: vector table plus RAM-transaction scoreboard.
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] DM_addr, DM_writeData, DM_readData;
    logic        DM_writeEnable, DM_readEnable, stall;
    logic        mem_req, mem_we, mem_ready, mem_rvalid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    logic        man_rv;
    logic [63:0] man_rd;
    logic        model_rv = 1'b0;
    logic [63:0] model_rd = '0;
    int unsigned rv_lat;

    assign mem_rvalid = model_rv | man_rv;
    assign mem_rdata  = man_rv ? man_rd : model_rd;

    dmem_bridge #(.N(64), .SB_DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .DM_addr(DM_addr), .DM_writeData(DM_writeData),
        .DM_writeEnable(DM_writeEnable), .DM_readEnable(DM_readEnable),
        .DM_readData(DM_readData), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { bit we; logic [63:0] addr; logic [63:0] data; } txn_t;
    typedef struct { bit is_load; logic [63:0] addr; logic [63:0] data; int unsigned rv; int exp_stall; } vec_t;

    txn_t        exp_q[$];
    txn_t        obs [256];
    int unsigned obs_wr = 0;
    int unsigned obs_rd = 0;
    logic [63:0] ram     [logic [63:0]];
    logic [63:0] ref_mem [logic [63:0]];
    bit          pend = 1'b0;
    int unsigned pend_wait = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    // Backing-RAM model: records every transfer, answers reads after rv_lat extra cycles.
    always @(negedge clk) begin
        if (pend) begin
            if (pend_wait == 0) begin
                model_rv = 1'b1;
                pend     = 1'b0;
            end else begin
                model_rv  = 1'b0;
                pend_wait = pend_wait - 1;
            end
        end else begin
            model_rv = 1'b0;
        end
        if (!reset && mem_req && mem_ready) begin
            obs[obs_wr % 256] = '{mem_we, mem_addr, mem_wdata};
            obs_wr = obs_wr + 1;
            if (mem_we) ram[mem_addr] = mem_wdata;
            else begin
                pend      = 1'b1;
                pend_wait = rv_lat;
                model_rd  = ram.exists(mem_addr) ? ram[mem_addr] : '0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic sb_check();
        txn_t o, e;
        while (obs_rd != obs_wr) begin
            o = obs[obs_rd % 256];
            obs_rd++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got we=%0b addr=%h, required no transfer", o.we, o.addr);
            end else begin
                e = exp_q.pop_front();
                if (o.we !== e.we || o.addr !== e.addr || (e.we && o.data !== e.data)) begin
                    errors++;
                    $display("FAIL sb_txn: got we=%0b addr=%h data=%h required we=%0b addr=%h data=%h",
                             o.we, o.addr, o.data, e.we, e.addr, e.data);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [63:0] a, input logic [63:0] d);
        int unsigned n = 0;
        DM_addr = a; DM_writeData = d; DM_writeEnable = 1'b1; DM_readEnable = 1'b0;
        exp_q.push_back('{1'b1, a, d});
        ref_mem[a] = d;
        @(negedge clk);
        while (stall && n < 40) begin n++; @(negedge clk); end
        if (n >= 40) chk("store_timeout", 64'(stall), 64'd0);
        tick();
        DM_writeEnable = 1'b0;
        sb_check();
    endtask

    task automatic do_load(input logic [63:0] a, input bit with_we,
                           output int unsigned sc, output logic [63:0] d);
        DM_addr = a; DM_writeData = 64'h9999; DM_readEnable = 1'b1; DM_writeEnable = with_we;
        exp_q.push_back('{1'b0, a, '0});
        sc = 0;
        @(negedge clk);
        while (stall && sc < 100) begin sc++; @(negedge clk); end
        if (sc >= 100) chk("load_timeout", 64'(stall), 64'd0);
        d = DM_readData;
        tick();
        DM_readEnable = 1'b0; DM_writeEnable = 1'b0;
        sb_check();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        vec_t        vt [9];
        int unsigned sc;
        logic [63:0] d, held;

        vt[0] = '{1'b0, 64'h100, 64'h1111_2222, 0, -1};
        vt[1] = '{1'b0, 64'h108, 64'hAAAA, 0, -1};
        vt[2] = '{1'b1, 64'h100, 64'h1111_2222, 0, -1};
        vt[3] = '{1'b1, 64'h108, 64'hAAAA, 2, 5};
        vt[4] = '{1'b0, 64'h100, 64'h5555, 0, -1};
        vt[5] = '{1'b1, 64'h100, 64'h5555, 1, -1};
        vt[6] = '{1'b1, 64'h108, 64'hAAAA, 0, 3};
        vt[7] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 0, -1};
        vt[8] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 3, -1};

        reset = 1'b1; DM_addr = '0; DM_writeData = '0; DM_writeEnable = 1'b0; DM_readEnable = 1'b0;
        mem_ready = 1'b0; man_rv = 1'b0; man_rd = '0; rv_lat = 0;
        tick(); tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_rdata", DM_readData, 64'd0);
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_addr", mem_addr, 64'd0);
        chk("rst_wdata", mem_wdata, 64'd0);
        tick();

        // Single store with RAM ready.
        mem_ready = 1'b1;
        DM_addr = 64'h10; DM_writeData = 64'hAA; DM_writeEnable = 1'b1;
        exp_q.push_back('{1'b1, 64'h10, 64'hAA}); ref_mem[64'h10] = 64'hAA;
        @(negedge clk);
        chk("st_stall", 64'(stall), 64'd0);
        tick();
        DM_writeEnable = 1'b0;
        @(negedge clk);
        chk("st_req", 64'(mem_req), 64'd1);
        chk("st_we", 64'(mem_we), 64'd1);
        chk("st_addr", mem_addr, 64'h10);
        chk("st_wdata", mem_wdata, 64'hAA);
        tick();
        @(negedge clk);
        chk("st_drained", 64'(mem_req), 64'd0);
        tick();
        sb_check();

        // Back-pressure: three stores into a two-entry buffer with RAM not ready.
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            DM_addr = 64'h50 + 64'(8 * i); DM_writeData = 64'hB0 + 64'(i); DM_writeEnable = 1'b1;
            exp_q.push_back('{1'b1, DM_addr, DM_writeData}); ref_mem[DM_addr] = DM_writeData;
            @(negedge clk);
            chk("bp_stall", 64'(stall), (i == 2) ? 64'd1 : 64'd0);
            if (i < 2) tick();
        end
        tick();
        mem_ready = 1'b1;
        @(negedge clk);
        chk("bp_still_stall", 64'(stall), 64'd1);
        chk("bp_head0", mem_addr, 64'h50);
        tick();
        @(negedge clk);
        chk("bp_release", 64'(stall), 64'd0);
        chk("bp_head1", mem_addr, 64'h58);
        tick();
        DM_writeEnable = 1'b0;
        @(negedge clk);
        chk("bp_head2", mem_addr, 64'h60);
        chk("bp_head2_data", mem_wdata, 64'hB2);
        tick(); tick();
        sb_check();

        // Vector table.
        for (int i = 0; i < 9; i++) begin
            if (!vt[i].is_load) do_store(vt[i].addr, vt[i].data);
            else begin
                rv_lat = vt[i].rv;
                do_load(vt[i].addr, 1'b0, sc, d);
                chk($sformatf("vec%0d_data", i), d, vt[i].data);
                if (vt[i].exp_stall >= 0) chk($sformatf("vec%0d_stall", i), 64'(sc), 64'(vt[i].exp_stall));
            end
        end

        // Load with empty buffer, minimum latency.
        do_store(64'h20, 64'h1234);
        tick(); tick();
        rv_lat = 0;
        do_load(64'h20, 1'b0, sc, d);
        chk("ld_min_stall", 64'(sc), 64'd3);
        chk("ld_min_data", d, 64'h1234);
        @(negedge clk);
        chk("ld_no_rereq", 64'(mem_req), 64'd0);
        tick();

        // Load queued behind two buffered stores.
        mem_ready = 1'b0;
        do_store(64'h30, 64'hC0FFEE);
        do_store(64'h38, 64'hBEEF);
        mem_ready = 1'b1;
        do_load(64'h30, 1'b0, sc, d);
        chk("ld_behind_stall", 64'(sc), 64'd4);
        chk("ld_behind_data", d, 64'hC0FFEE);

        // Simultaneous load and store acts as a load only.
        do_load(64'h38, 1'b1, sc, d);
        chk("rw_both_data", d, ref_mem[64'h38]);
        tick(); tick();
        sb_check();

        // Reset while waiting for read data; the late rvalid must be ignored.
        rv_lat = 4;
        DM_addr = 64'h60; DM_readEnable = 1'b1;
        exp_q.push_back('{1'b0, 64'h60, '0});
        tick(); tick();
        reset = 1'b1; DM_readEnable = 1'b0;
        tick(); tick();
        reset = 1'b0;
        man_rv = 1'b1; man_rd = 64'hBEEF;
        tick();
        man_rv = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        @(negedge clk);
        chk("rst_mid_req", 64'(mem_req), 64'd0);
        chk("rst_mid_stall", 64'(stall), 64'd0);
        chk("rst_mid_rdata", DM_readData, 64'd0);
        tick();
        sb_check();

        // Spurious rvalid while idle.
        rv_lat = 0;
        do_load(64'h108, 1'b0, sc, held);
        man_rv = 1'b1; man_rd = 64'hDEAD;
        @(negedge clk);
        chk("spur_stall", 64'(stall), 64'd0);
        chk("spur_req", 64'(mem_req), 64'd0);
        tick();
        man_rv = 1'b0;
        @(negedge clk);
        chk("spur_rdata", DM_readData, held);
        tick();
        do_load(64'h108, 1'b0, sc, d);
        chk("post_spur_stall", 64'(sc), 64'd3);
        chk("post_spur_data", d, 64'hAAAA);

        tick(); tick();
        sb_check();
        chk("sb_leftover", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
